// File: rtl/dot_product_accumulator.sv
// Streaming unsigned dot-product engine: accumulates sum(a*b) over LEN pairs
// and hands back the wrapped sum plus a sticky carry-out flag.
module dot_product_accumulator #(
   parameter int INPUT_WIDTH = 16,
   parameter int LEN_WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_start,
   input  logic [LEN_WIDTH-1:0]       i_len,
   input  logic                       i_in_valid,
   output logic                       o_in_ready,
   input  logic [INPUT_WIDTH-1:0]     i_in_a,
   input  logic [INPUT_WIDTH-1:0]     i_in_b,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [2*INPUT_WIDTH-1:0]   o_out_result,
   output logic                       o_out_overflow,
   output logic                       o_busy
);
   localparam int OUTPUT_WIDTH = 2*INPUT_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t                  r_state;
   logic [OUTPUT_WIDTH-1:0] r_acc;
   logic                    r_ovf;
   logic [LEN_WIDTH-1:0]    r_count;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic                    r_busy;

   logic [OUTPUT_WIDTH-1:0] w_prod;
   logic [OUTPUT_WIDTH:0]   w_sum;
   logic                    w_accept;

   // Full-width product; the extra sum bit is the carry out of the accumulator.
   assign w_prod   = OUTPUT_WIDTH'(i_in_a) * OUTPUT_WIDTH'(i_in_b);
   assign w_sum    = {1'b0, r_acc} + {1'b0, w_prod};
   assign w_accept = i_in_valid & r_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_count     <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_acc  <= '0;
                  r_ovf  <= 1'b0;
                  r_busy <= 1'b1;
                  if (i_len != '0) begin
                     r_count    <= i_len;
                     r_in_ready <= 1'b1;
                     r_state    <= S_ACCUM;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_ACCUM: begin
               if (w_accept) begin
                  r_acc   <= w_sum[OUTPUT_WIDTH-1:0];
                  r_ovf   <= r_ovf | w_sum[OUTPUT_WIDTH];
                  r_count <= r_count - 1'b1;
                  if (r_count == LEN_WIDTH'(1)) begin
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // acc/ovf stay put after the handshake until the next start clears them.
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready     = r_in_ready;
   assign o_out_valid    = r_out_valid;
   assign o_out_result   = r_acc;
   assign o_out_overflow = r_ovf;
   assign o_busy         = r_busy;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized bench for dot_product_accumulator against a wide-integer sum model.
module tb_dot_product_accumulator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_len = '0;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [15:0] i_in_a = '0;
   logic [15:0] i_in_b = '0;
   logic        o_out_valid;
   logic        i_out_ready = 1'b0;
   logic [31:0] o_out_result;
   logic        o_out_overflow;
   logic        o_busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] qa[$];
   logic [15:0] qb[$];
   bit          qv[$];

   always #5 clk = ~clk;

   dot_product_accumulator #(.INPUT_WIDTH(16), .LEN_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_a(i_in_a), .i_in_b(i_in_b),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_out_result(o_out_result), .o_out_overflow(o_out_overflow),
      .o_busy(o_busy)
   );

   // Exact sum in 64 bits: result is the low word, overflow means the sum ever passed 2^32.
   task automatic model(input int n, output logic [31:0] res, output logic ovf);
      logic [63:0] s;
      s = 64'd0;
      for (int i = 0; i < n; i++) s += 64'(qa[i]) * 64'(qb[i]);
      res = s[31:0];
      ovf = (s[63:32] != 32'd0);
   endtask

   // mode 0: valid held high, 1: random gaps, 2: valid pattern from qv
   task automatic run_op(input int n, input int mode, input int stall,
                         output logic [31:0] res, output logic ovf, output int accepts);
      int idx, cyc;
      bit acc_now;
      logic [31:0] r0;
      logic o0;
      idx = 0; cyc = 0; accepts = 0;
      i_start = 1'b1; i_len = 8'(n);
      @(posedge clk); #1;
      i_start = 1'b0;
      while (idx < n && cyc < 2000) begin
         case (mode)
            0:       i_in_valid = 1'b1;
            1:       i_in_valid = ($urandom_range(0, 2) != 0);
            default: i_in_valid = (cyc < qv.size()) ? qv[cyc] : 1'b1;
         endcase
         i_in_a = qa[idx]; i_in_b = qb[idx];
         acc_now = i_in_valid && o_in_ready;
         @(posedge clk); #1;
         if (acc_now) begin idx++; accepts++; end
         cyc++;
      end
      i_in_valid = 1'b0;
      if (cyc >= 2000) begin
         total++; bad++;
         $display("FAIL accept_timeout: accepted %0d of %0d", idx, n);
      end
      total++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL done_latency: valid=%b ready=%b busy=%b required 1 0 1",
                  o_out_valid, o_in_ready, o_busy);
      end
      r0 = o_out_result; o0 = o_out_overflow;
      for (int s = 0; s < stall; s++) begin
         i_start = (s % 2 == 0); i_len = 8'd7;
         @(posedge clk); #1;
         total++;
         if (o_out_valid !== 1'b1 || o_out_result !== r0 || o_out_overflow !== o0) begin
            bad++;
            $display("FAIL stall_stable: valid=%b res=%h ovf=%b required 1 %h %b",
                     o_out_valid, o_out_result, o_out_overflow, r0, o0);
         end
      end
      res = o_out_result; ovf = o_out_overflow;
      // start coincides with the output handshake and must be ignored
      i_start = 1'b1; i_len = 8'd5; i_out_ready = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_out_ready = 1'b0;
      total++;
      if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
         bad++;
         $display("FAIL back_to_idle: valid=%b busy=%b ready=%b required 0 0 0",
                  o_out_valid, o_busy, o_in_ready);
      end
   endtask

   task automatic check_result(input string nm, input logic [31:0] res, input logic ovf,
                               input logic [31:0] eres, input logic eovf);
      total++;
      if (res !== eres || ovf !== eovf) begin
         bad++;
         $display("FAIL %s: result=%h ovf=%b required %h %b", nm, res, ovf, eres, eovf);
      end
   endtask

   task automatic test_reset;
      #1;
      total++;
      if (o_in_ready !== 0 || o_out_valid !== 0 || o_out_result !== 0 ||
          o_out_overflow !== 0 || o_busy !== 0) begin
         bad++;
         $display("FAIL reset_state: rdy=%b vld=%b res=%h ovf=%b busy=%b required all 0",
                  o_in_ready, o_out_valid, o_out_result, o_out_overflow, o_busy);
      end
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic [31:0] r, er; logic o, eo; int acc;
      qa = '{16'd1, 16'd3, 16'd5, 16'd7}; qb = '{16'd2, 16'd4, 16'd6, 16'd8};
      model(4, er, eo);
      run_op(4, 0, 0, r, o, acc);
      check_result("basic_len4", r, o, 32'd100, 1'b0);
      check_result("basic_model", r, o, er, eo);
   endtask

   task automatic test_len_zero;
      logic [31:0] r; logic o; int acc;
      run_op(0, 0, 0, r, o, acc);
      check_result("len_zero", r, o, 32'd0, 1'b0);
   endtask

   task automatic test_gaps;
      logic [31:0] r; logic o; int acc;
      qa = '{16'd10, 16'd10, 16'd10}; qb = '{16'd10, 16'd10, 16'd10};
      qv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run_op(3, 2, 0, r, o, acc);
      check_result("gaps_len3", r, o, 32'd300, 1'b0);
      total++;
      if (acc !== 3) begin
         bad++;
         $display("FAIL gaps_accepts: got %0d required 3", acc);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] r; logic o; int acc;
      qa = '{16'hFFFF, 16'hFFFF}; qb = '{16'hFFFF, 16'hFFFF};
      run_op(2, 0, 0, r, o, acc);
      check_result("overflow", r, o, 32'hFFFC0002, 1'b1);
   endtask

   task automatic test_stall;
      logic [31:0] r, er; logic o, eo; int acc;
      qa = '{16'd1234, 16'hFFFF, 16'd77}; qb = '{16'd4321, 16'hFFFF, 16'd9};
      model(3, er, eo);
      run_op(3, 0, 5, r, o, acc);
      check_result("stall_result", r, o, er, eo);
   endtask

   task automatic test_random;
      logic [31:0] r, er; logic o, eo; int acc, n;
      for (int t = 0; t < 12; t++) begin
         n = $urandom_range(1, 24);
         qa.delete(); qb.delete();
         for (int i = 0; i < n; i++) begin
            qa.push_back((t % 3 == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF)) : 16'($urandom));
            qb.push_back(16'($urandom));
         end
         model(n, er, eo);
         run_op(n, 1, $urandom_range(0, 3), r, o, acc);
         check_result($sformatf("random_%0d", t), r, o, er, eo);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r; logic o; int acc;
      i_start = 1'b1; i_len = 8'd4;
      @(posedge clk); #1;
      i_start = 1'b0; i_in_valid = 1'b1; i_in_a = 16'd100; i_in_b = 16'd100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (o_in_ready !== 0 || o_out_valid !== 0 || o_out_result !== 0 ||
          o_out_overflow !== 0 || o_busy !== 0) begin
         bad++;
         $display("FAIL reset_mid: rdy=%b vld=%b res=%h ovf=%b busy=%b required all 0",
                  o_in_ready, o_out_valid, o_out_result, o_out_overflow, o_busy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      qa = '{16'd3}; qb = '{16'd3};
      run_op(1, 0, 0, r, o, acc);
      check_result("after_reset", r, o, 32'd9, 1'b0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_len_zero;
      test_gaps;
      test_overflow;
      test_stall;
      test_random;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
